// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO for the USB bulk endpoint to
// SD block-write datapath. Tracks occupancy, raises almost-full/almost-empty
// watermarks and latches sticky overflow/underflow flags; supports a flush.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// read data; without it read_data is registered with 1-cycle latency.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Reject configurations whose watermarks or depth make no sense.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: need 0 < AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_ok, rd_ok;

  // A full FIFO still takes a write when a read frees the slot in the same
  // cycle; a write into an empty FIFO never makes a same-cycle read legal.
  assign wr_ok = write_enable & (~fifo_full | read_enable);
  assign rd_ok = read_enable & ~fifo_empty;

  // Flags decode only the registered count, so they move with count.
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (n_rst && !clear && wr_ok) mem[wptr] <= write_data;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write_enable && !wr_ok) overflow  <= 1'b1;
      if (read_enable && !rd_ok)  underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Show-ahead: the head word is presented whenever the FIFO holds data.
  always_comb begin
    read_data = '0;
    if (!fifo_empty) read_data = mem[rptr];
  end
`else
  logic [WIDTH-1:0] rd_q;

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) rd_q <= '0;
    else if (rd_ok)      rd_q <= mem[rptr];
  end

  assign read_data = rd_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16, AF=12, AE=3).
// Scoreboard queue holds written words; reads pop and compare.
module tb_sync_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 3;

  logic             clk = 1'b0;
  logic             n_rst, clear, write_enable, read_enable;
  logic [WIDTH-1:0] write_data, read_data;
  logic             fifo_empty, fifo_full, almost_full, almost_empty;
  logic [4:0]       count;
  logic             overflow, underflow;

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] q[$];
  int               mcnt = 0;
  logic             m_of = 1'b0, m_uf = 1'b0;
  logic [WIDTH-1:0] last_rd = '0;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".count"},  32'(count), 32'(mcnt));
    chk({tag, ".empty"},  32'(fifo_empty), 32'(mcnt == 0));
    chk({tag, ".full"},   32'(fifo_full), 32'(mcnt == DEPTH));
    chk({tag, ".afull"},  32'(almost_full), 32'(mcnt >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(mcnt <= AE));
    chk({tag, ".ovf"},    32'(overflow), 32'(m_of));
    chk({tag, ".unf"},    32'(underflow), 32'(m_uf));
  endtask

  // One cycle of traffic; model predicts acceptance, data and flags.
  task automatic op(input logic we, input logic [WIDTH-1:0] wd, input logic re, input string tag);
    logic rd_ok, wr_ok;
    logic [WIDTH-1:0] expv;
    rd_ok = re && (mcnt > 0);
    wr_ok = we && ((mcnt < DEPTH) || re);
    expv  = '0;
    if (rd_ok) expv = q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
    if (rd_ok) chk({tag, ".head"}, 32'(read_data), 32'(expv));
`endif
    write_enable = we; write_data = wd; read_enable = re;
    cyc();
    write_enable = 1'b0; read_enable = 1'b0;
    if (wr_ok) q.push_back(wd);
    if (wr_ok && !rd_ok) mcnt++;
    if (rd_ok && !wr_ok) mcnt--;
    if (we && !wr_ok) m_of = 1'b1;
    if (re && !rd_ok) m_uf = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".show"}, 32'(read_data), (mcnt > 0) ? 32'(q[0]) : 32'h0);
`else
    if (rd_ok) last_rd = expv;
    chk({tag, ".rdata"}, 32'(read_data), 32'(last_rd));
`endif
    chk_flags(tag);
  endtask

  task automatic model_reset();
    q.delete();
    mcnt = 0; m_of = 1'b0; m_uf = 1'b0; last_rd = '0;
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; write_enable = 1'b0; read_enable = 1'b0; write_data = '0;

    // Reset held two cycles
    cyc(); cyc();
    model_reset();
    chk("rst.rdata", 32'(read_data), 32'h0);
    chk_flags("rst");
    n_rst = 1'b1;

    // Basic round trip
    op(1'b1, 8'hA5, 1'b0, "basic.w0");
    op(1'b1, 8'h3C, 1'b0, "basic.w1");
    op(1'b0, 8'h00, 1'b1, "basic.r0");
    op(1'b0, 8'h00, 1'b1, "basic.r1");

    // Fill, partial drain, refill across the pointer wrap, full drain
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, "fill");
    for (int i = 0; i < 8; i++)  op(1'b0, 8'h00, 1'b1, "wrap.rd");
    for (int i = 0; i < 8; i++)  op(1'b1, 8'(8'h10 + i), 1'b0, "wrap.wr");
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, "wrap.drain");

    // Overflow on full, drain, underflow on empty
    for (int i = 0; i < 16; i++) op(1'b1, 8'(8'h20 + i), 1'b0, "ovf.fill");
    op(1'b1, 8'hFF, 1'b0, "ovf.reject");
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, "ovf.drain");
    op(1'b0, 8'h00, 1'b1, "unf.reject");

    // Clear with concurrent read/write: both discarded, flags cleared
    clear = 1'b1; write_enable = 1'b1; write_data = 8'hEE; read_enable = 1'b1;
    cyc();
    clear = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    model_reset();
    chk("clr.rdata", 32'(read_data), 32'h0);
    chk_flags("clr");

    // Simultaneous read+write while full
    for (int i = 0; i < 16; i++) op(1'b1, 8'(8'h30 + i), 1'b0, "sim.fill");
    op(1'b1, 8'h55, 1'b1, "sim.full_rw");
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, "sim.drain");
    chk("sim.last55", 32'(last_rd), 32'h55);

    // Simultaneous read+write while empty: write lands, read flagged
    op(1'b1, 8'h66, 1'b1, "sim.empty_rw");
    op(1'b0, 8'h00, 1'b1, "sim.rd66");

    // Mid-operation reset at count 9 with a write in flight
    for (int i = 0; i < 10; i++) op(1'b1, 8'(8'h40 + i), 1'b0, "mrst.fill");
    op(1'b0, 8'h00, 1'b1, "mrst.rd");
    n_rst = 1'b0; write_enable = 1'b1; write_data = 8'h77;
    cyc();
    n_rst = 1'b1; write_enable = 1'b0;
    model_reset();
    chk("mrst.rdata", 32'(read_data), 32'h0);
    chk_flags("mrst");
    op(1'b1, 8'h99, 1'b0, "mrst.w");
    op(1'b0, 8'h00, 1'b1, "mrst.r");

    // Watermark sweep 0 -> 16 -> 0
    for (int i = 0; i < 16; i++) op(1'b1, 8'(8'hC0 + i), 1'b0, "wm.up");
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, "wm.down");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
